// File: rtl/dataflow_sched_ctrl.sv
// dataflow_sched_ctrl
// Schedules a convolution as a sequence of rounds on a PE array. For each
// round it picks the cheapest of four dataflows from per-kernel cost tables
// (or keeps the round-0 choice when 'same' is set), waits for the array,
// times the round with a down-counter and accumulates the spent cycles.
//
// Optional feature: define DATAFLOW_SCHED_ABORT_EN to add the 'abort' input,
// which drops any running schedule back to IDLE on the next edge.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results of the last schedule are held
// DIV   | rounds = ceil(total / per-round), one subtraction per cycle
// SEL   | pick dataflow and cost for the current round
// WAIT  | hold until the PE array is ready, then issue the round
// RUN   | count down the round cost, accumulate on the last cycle
// DONE  | one-cycle completion pulse
module dataflow_sched_ctrl #(
    parameter int N  = 16,
    parameter int CW = 19,
    parameter int TW = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [5:0]          kernelsize,
    input  logic                same,
    input  logic [CW-1:0]       OSIS [N][N],
    input  logic [CW-1:0]       OSWS [N][N],
    input  logic [CW-1:0]       WSIS [N][N],
    input  logic [CW-1:0]       WSWS [N][N],
    input  logic signed [31:0]  input_totalnum,
    input  logic signed [31:0]  total_inputmapnum,
    input  logic                array_rdy,
`ifdef DATAFLOW_SCHED_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic [1:0]          df_sel,
    output logic                round_valid,
    output logic [31:0]         round_idx,
    output logic [CW-1:0]       round_cost,
    output logic [TW-1:0]       total_cycles,
    output logic                done,
    output logic                err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [6:0] KMAX = 7'(N);

    typedef enum logic [2:0] {IDLE, DIV, SEL, WAIT, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [5:0]         ks_q;
    logic               same_q;
    logic signed [31:0] rem_q;
    logic signed [31:0] map_q;
    logic [31:0]        rounds_q;
    logic [IW-1:0]      col_q;
    logic [CW-1:0]      timer_q;

    logic               cfg_ok;
    logic               abort_hit;
    logic [IW-1:0]      row;
    logic [1:0]         sel_df;
    logic [CW-1:0]      sel_cost;
    logic [CW-1:0]      cost_eff;
    logic [TW:0]        sum_w;
    logic [TW-1:0]      total_sat;

`ifdef DATAFLOW_SCHED_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign cfg_ok = (kernelsize != 6'd0) && ({1'b0, kernelsize} <= KMAX)
                    && (input_totalnum > 32'sd0) && (total_inputmapnum > 32'sd0);

    // Row is only used after a legal start, so ks_q is in 1..N here.
    assign row = IW'(ks_q - 6'd1);

    // A zero-cost entry still occupies the array for one cycle.
    assign cost_eff  = (round_cost == '0) ? CW'(1) : round_cost;
    assign sum_w     = {1'b0, total_cycles} + (TW + 1)'(cost_eff);
    assign total_sat = sum_w[TW] ? '1 : sum_w[TW-1:0];

    // Dataflow choice: strict less-than keeps the lowest index on ties;
    // with 'same' the round-0 dataflow is reused after the first round.
    always_comb begin
        sel_df   = 2'd0;
        sel_cost = OSIS[row][col_q];
        if (OSWS[row][col_q] < sel_cost) begin
            sel_df   = 2'd1;
            sel_cost = OSWS[row][col_q];
        end
        if (WSIS[row][col_q] < sel_cost) begin
            sel_df   = 2'd2;
            sel_cost = WSIS[row][col_q];
        end
        if (WSWS[row][col_q] < sel_cost) begin
            sel_df   = 2'd3;
            sel_cost = WSWS[row][col_q];
        end
        if (same_q && (round_idx != 32'd0)) begin
            sel_df = df_sel;
            case (df_sel)
                2'd0:    sel_cost = OSIS[row][col_q];
                2'd1:    sel_cost = OSWS[row][col_q];
                2'd2:    sel_cost = WSIS[row][col_q];
                default: sel_cost = WSWS[row][col_q];
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: if (start && cfg_ok) state_nxt = DIV;
            DIV:  if (rem_q <= map_q) state_nxt = SEL;
            SEL:  state_nxt = WAIT;
            WAIT: if (array_rdy) state_nxt = RUN;
            RUN: begin
                if (timer_q == CW'(1))
                    state_nxt = ((round_idx + 32'd1) < rounds_q) ? SEL : DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    // Datapath: configuration capture, division, selection, timing, totals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks_q         <= '0;
            same_q       <= 1'b0;
            rem_q        <= '0;
            map_q        <= '0;
            rounds_q     <= '0;
            col_q        <= '0;
            timer_q      <= '0;
            df_sel       <= '0;
            round_valid  <= 1'b0;
            round_idx    <= '0;
            round_cost   <= '0;
            total_cycles <= '0;
            err          <= 1'b0;
        end else begin
            err         <= 1'b0;
            round_valid <= 1'b0;
            if (!abort_hit) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_ok) begin
                                ks_q         <= kernelsize;
                                same_q       <= same;
                                rem_q        <= input_totalnum;
                                map_q        <= total_inputmapnum;
                                rounds_q     <= '0;
                                col_q        <= '0;
                                round_idx    <= '0;
                                total_cycles <= '0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    DIV: begin
                        rem_q    <= rem_q - map_q;
                        rounds_q <= rounds_q + 32'd1;
                    end
                    SEL: begin
                        df_sel     <= sel_df;
                        round_cost <= sel_cost;
                    end
                    WAIT: begin
                        if (array_rdy) begin
                            round_valid <= 1'b1;
                            timer_q     <= cost_eff;
                        end
                    end
                    RUN: begin
                        if (timer_q == CW'(1)) begin
                            total_cycles <= total_sat;
                            round_idx    <= round_idx + 32'd1;
                            col_q        <= (col_q == IW'(N - 1)) ? '0 : col_q + 1'b1;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dataflow_sched_ctrl.sv
// Testbench for dataflow_sched_ctrl: a round-level model (ceil division,
// per-round argmin over the cost tables, saturating sum) feeds a compare
// process that checks every issued round and every RUN cycle's total.
module tb_dataflow_sched_ctrl;

    localparam int N  = 16;
    localparam int CW = 19;
    localparam int TW = 10;

    logic                clk;
    logic                rst;
    logic                start;
    logic [5:0]          kernelsize;
    logic                same;
    logic [CW-1:0]       osis [N][N];
    logic [CW-1:0]       osws [N][N];
    logic [CW-1:0]       wsis [N][N];
    logic [CW-1:0]       wsws [N][N];
    logic signed [31:0]  input_totalnum;
    logic signed [31:0]  total_inputmapnum;
    logic                array_rdy;
`ifdef DATAFLOW_SCHED_ABORT_EN
    logic                abort;
`endif
    logic                busy;
    logic [1:0]          df_sel;
    logic                round_valid;
    logic [31:0]         round_idx;
    logic [CW-1:0]       round_cost;
    logic [TW-1:0]       total_cycles;
    logic                done;
    logic                err;

    dataflow_sched_ctrl #(.N(N), .CW(CW), .TW(TW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .kernelsize(kernelsize),
        .same(same),
        .OSIS(osis),
        .OSWS(osws),
        .WSIS(wsis),
        .WSWS(wsws),
        .input_totalnum(input_totalnum),
        .total_inputmapnum(total_inputmapnum),
        .array_rdy(array_rdy),
`ifdef DATAFLOW_SCHED_ABORT_EN
        .abort(abort),
`endif
        .busy(busy),
        .df_sel(df_sel),
        .round_valid(round_valid),
        .round_idx(round_idx),
        .round_cost(round_cost),
        .total_cycles(total_cycles),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- model ----------------
    int     exp_df[$];
    int     exp_cost[$];
    longint exp_total;
    int     pend;
    int     cur_eff;
    int     rv_cnt;
    int     done_cnt = 0;
    bit     chk_en = 1'b0;
    int     e_df, e_cost;

    function automatic longint sat_add(longint a, longint b);
        longint mx = (longint'(1) << TW) - 1;
        return (a + b > mx) ? mx : a + b;
    endfunction

    function automatic int tbl(int d, int r, int c);
        case (d)
            0:       return int'(osis[r][c]);
            1:       return int'(osws[r][c]);
            2:       return int'(wsis[r][c]);
            default: return int'(wsws[r][c]);
        endcase
    endfunction

    task automatic plan(int ks, bit sm, int tot, int mp);
        int nr, d0, c, bd, bc;
        nr = (tot + mp - 1) / mp;
        d0 = 0;
        exp_df.delete();
        exp_cost.delete();
        for (int r = 0; r < nr; r++) begin
            c = r % N;
            if (sm && r > 0) begin
                bd = d0;
                bc = tbl(d0, ks - 1, c);
            end else begin
                bd = 0;
                bc = tbl(0, ks - 1, c);
                for (int d = 1; d < 4; d++)
                    if (tbl(d, ks - 1, c) < bc) begin
                        bd = d;
                        bc = tbl(d, ks - 1, c);
                    end
            end
            if (r == 0) d0 = bd;
            exp_df.push_back(bd);
            exp_cost.push_back(bc);
        end
        exp_total = 0;
        pend      = 0;
        rv_cnt    = 0;
    endtask

    // Compare process: per-round outputs at issue, running total each RUN cycle.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (round_valid) begin
                if (exp_df.size() == 0) begin
                    check("extra_round", rv_cnt, -1);
                end else begin
                    e_df   = exp_df.pop_front();
                    e_cost = exp_cost.pop_front();
                    check("rv_df", df_sel, e_df);
                    check("rv_cost", round_cost, e_cost);
                    check("rv_idx", round_idx, rv_cnt);
                    check("rv_total", total_cycles, exp_total);
                    cur_eff = (e_cost == 0) ? 1 : e_cost;
                    pend    = cur_eff;
                end
                rv_cnt++;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) exp_total = sat_add(exp_total, cur_eff);
                check("run_total", total_cycles, exp_total);
            end
            if (done) begin
                check("done_rounds_left", exp_df.size(), 0);
                check("done_total", total_cycles, exp_total);
                done_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cell(int d, int r, int c, int v);
        case (d)
            0:       osis[r][c] = CW'(v);
            1:       osws[r][c] = CW'(v);
            2:       wsis[r][c] = CW'(v);
            default: wsws[r][c] = CW'(v);
        endcase
    endtask

    task automatic set_row(int d, int r, int v);
        for (int c = 0; c < N; c++) set_cell(d, r, c, v);
    endtask

    task automatic fill_all(int v);
        for (int r = 0; r < N; r++)
            for (int d = 0; d < 4; d++) set_row(d, r, v);
    endtask

    // Starts a schedule, then scrambles the inputs and issues a legal but
    // unwanted start while busy; neither may disturb the running schedule.
    task automatic launch(int ks, bit sm, int tot, int mp);
        plan(ks, sm, tot, mp);
        chk_en = 1'b1;
        @(posedge clk); #1;
        kernelsize = 6'(ks); same = sm;
        input_totalnum = tot; total_inputmapnum = mp;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        kernelsize = 6'd1; same = ~sm;
        input_totalnum = 1; total_inputmapnum = 1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        check("done_seen", done_cnt - d0, 1);
        @(posedge clk); #1;
        check("idle_after_done", busy, 0);
    endtask

    task automatic wait_rv(int n, int budget);
        int i = 0;
        while (rv_cnt < n && i < budget) begin
            @(posedge clk);
            i++;
        end
        check("rv_reached", (rv_cnt >= n), 1);
    endtask

    task automatic err_case(string nm, int ks, int tot, int mp, longint prev_total);
        int errs = 0;
        int busys = 0;
        @(posedge clk); #1;
        kernelsize = 6'(ks); input_totalnum = tot; total_inputmapnum = mp;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            errs  += int'(err);
            busys += int'(busy);
        end
        check({nm, "_err"}, errs, 1);
        check({nm, "_busy"}, busys, 0);
        check({nm, "_hold_total"}, total_cycles, prev_total);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int quiet;
        rst = 1'b1; start = 1'b0; kernelsize = '0; same = 1'b0;
        input_totalnum = 0; total_inputmapnum = 0; array_rdy = 1'b1;
`ifdef DATAFLOW_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        fill_all(1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_df_sel", df_sel, 0);
        check("rst_round_valid", round_valid, 0);
        check("rst_round_idx", round_idx, 0);
        check("rst_round_cost", round_cost, 0);
        check("rst_total", total_cycles, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // All ones, same=1, 1000/200: five unit rounds.
        launch(2, 1'b1, 1000, 200);
        wait_done(500);
        check("a_rounds", rv_cnt, 5);
        check("a_df_sel", df_sel, 0);
        check("a_total", total_cycles, 5);

        // Row 1: WSIS cheapest, 1001/200 -> 6 rounds of 3.
        set_row(0, 1, 5); set_row(1, 1, 5); set_row(2, 1, 3); set_row(3, 1, 5);
        launch(2, 1'b0, 1001, 200);
        wait_done(500);
        check("b_rounds", rv_cnt, 6);
        check("b_df_sel", df_sel, 2);
        check("b_total", total_cycles, 18);

        // Locked versus free dataflow over two rounds.
        set_cell(0, 1, 0, 2); set_cell(1, 1, 0, 4); set_cell(2, 1, 0, 4); set_cell(3, 1, 0, 4);
        set_cell(0, 1, 1, 9); set_cell(1, 1, 1, 1); set_cell(2, 1, 1, 4); set_cell(3, 1, 1, 4);
        launch(2, 1'b1, 400, 200);
        wait_done(500);
        check("c_same_df_sel", df_sel, 0);
        check("c_same_total", total_cycles, 11);
        launch(2, 1'b0, 400, 200);
        wait_done(500);
        check("c_free_df_sel", df_sel, 1);
        check("c_free_total", total_cycles, 3);

        // Illegal configurations: err pulse, never busy, results held.
        err_case("e_ks0", 0, 1000, 200, 3);
        err_case("e_ks17", 17, 1000, 200, 3);
        err_case("e_map0", 2, 1000, 0, 3);
        err_case("e_totneg", 2, -5, 200, 3);
        check("e_hold_df_sel", df_sel, 1);
        check("e_hold_idx", round_idx, 2);

        // Ties and column wrap: 18 rounds over row 2.
        for (int c = 0; c < N; c++) begin
            case (c % 4)
                0: begin set_cell(0, 2, c, 6); set_cell(1, 2, c, 6); set_cell(2, 2, c, 6); set_cell(3, 2, c, 6); end
                1: begin set_cell(0, 2, c, 5); set_cell(1, 2, c, 2); set_cell(2, 2, c, 5); set_cell(3, 2, c, 2); end
                2: begin set_cell(0, 2, c, 3); set_cell(1, 2, c, 3); set_cell(2, 2, c, 1); set_cell(3, 2, c, 1); end
                default: begin set_cell(0, 2, c, 4); set_cell(1, 2, c, 4); set_cell(2, 2, c, 4); set_cell(3, 2, c, 0); end
            endcase
        end
        launch(3, 1'b0, 35, 2);
        wait_done(2000);
        check("t_rounds", rv_cnt, 18);
        check("t_df_sel", df_sel, 1);
        check("t_total", total_cycles, 48);

        // array_rdy low for 20 cycles in WAIT; zero-cost rounds last one cycle.
        for (int d = 0; d < 4; d++) set_row(d, 3, 0);
        array_rdy = 1'b0;
        launch(4, 1'b0, 400, 200);
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            quiet += int'(round_valid) + int'(!busy);
        end
        check("w_no_issue", quiet + rv_cnt, 0);
        #1 array_rdy = 1'b1;
        wait_done(500);
        check("w_rounds", rv_cnt, 2);
        check("w_total", total_cycles, 2);

        // Saturating total: 3 rounds of 500 into a 10-bit total.
        for (int d = 0; d < 4; d++) set_row(d, 5, 500);
        launch(6, 1'b0, 600, 200);
        wait_done(3000);
        check("s_total", total_cycles, 1023);

        // Reset in the middle of the second round.
        for (int d = 0; d < 4; d++) set_row(d, 4, 5);
        launch(5, 1'b0, 600, 200);
        wait_rv(2, 500);
        repeat (2) @(posedge clk);
        #1;
        check("r_partial_total", total_cycles, 5);
        chk_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("r_busy", busy, 0);
        check("r_df_sel", df_sel, 0);
        check("r_round_idx", round_idx, 0);
        check("r_round_cost", round_cost, 0);
        check("r_total", total_cycles, 0);
        check("r_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            quiet += int'(done) + int'(err) + int'(busy) + int'(round_valid);
        end
        check("r_quiet_after", quiet, 0);

        // Recovery after reset.
        fill_all(1);
        launch(2, 1'b1, 1000, 200);
        wait_done(500);
        check("rec_total", total_cycles, 5);

`ifdef DATAFLOW_SCHED_ABORT_EN
        for (int d = 0; d < 4; d++) set_row(d, 4, 5);
        launch(5, 1'b0, 600, 200);
        wait_rv(2, 500);
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_total", total_cycles, 5);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            quiet += int'(done) + int'(err) + int'(busy);
        end
        check("ab_quiet_after", quiet, 0);
        check("ab_hold_total", total_cycles, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dataflow_sched_ctrl.md
DATAFLOW_SCHED_CTRL -- requirements
Module: dataflow_sched_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: cost-table dimension and largest legal kernelsize.
REQ-002 SHALL have parameter CW, default 19: cost-entry width.
REQ-003 SHALL have parameter TW, default 48: total_cycles width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a schedule.
REQ-007 kernelsize  input  6  kernel size; selects cost-table row.
REQ-008 same  input  1  1 = dataflow locked after round 0.
REQ-009 OSIS, OSWS, WSIS, WSWS  input  [N][N] x CW  per-dataflow cycle-cost tables.
REQ-010 input_totalnum, total_inputmapnum  input  32 signed  total operations and operations per round.
REQ-011 array_rdy  input  1  PE array can accept a new round.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 df_sel  output  2  chosen dataflow: 0=OSIS, 1=OSWS, 2=WSIS, 3=WSWS.
REQ-014 round_valid  output  1  one-cycle pulse when a round is issued.
REQ-015 round_idx  output  32  index of current round.
REQ-016 round_cost  output  CW  cost of current round.
REQ-017 total_cycles  output  TW  accumulated cost of completed rounds.
REQ-018 done, err  output  1 each  one-cycle completion and configuration-error pulses.

Function
REQ-019 SHALL implement states IDLE, DIV, SEL, WAIT, RUN, DONE.
REQ-020 IDLE: on start with kernelsize in 1..N, input_totalnum>0 and total_inputmapnum>0, SHALL capture inputs, clear round_idx and total_cycles, and go to DIV.
REQ-021 IDLE: on start with any other configuration, SHALL pulse err next cycle and stay in IDLE.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 DIV: rounds = ceil(input_totalnum/total_inputmapnum) by repeated subtraction, one subtraction per cycle, then go to SEL.
REQ-024 SEL (1 cycle): row = kernelsize-1, col = round_idx mod N; SHALL register the minimum of the four table entries at [row][col] into round_cost and its index into df_sel.
REQ-025 Ties SHALL resolve to the lowest index: OSIS, then OSWS, then WSIS, then WSWS.
REQ-026 With same=1 and round_idx>0, SHALL keep df_sel from round 0 and load round_cost from that dataflow's table at [row][col].
REQ-027 WAIT: SHALL hold until array_rdy=1, then pulse round_valid for one cycle and enter RUN.
REQ-028 RUN: SHALL count down max(round_cost,1) cycles.
REQ-029 On the final RUN cycle, SHALL add max(round_cost,1) to total_cycles, saturating at 2^TW-1, and increment round_idx.
REQ-030 After the final RUN cycle, SHALL go to SEL if rounds remain, else to DONE.
REQ-031 DONE: SHALL pulse done for one cycle and return to IDLE.
REQ-032 total_cycles, df_sel, round_idx and round_cost SHALL hold their values in IDLE until the next legal start.
REQ-033 Captured configuration SHALL be immune to input changes while busy.

Reset
REQ-034 rst SHALL force IDLE immediately and clear every output to 0, including mid-schedule; no done or err pulse SHALL follow.

Configuration
REQ-035 With macro DATAFLOW_SCHED_ABORT_EN defined: input port abort (1 bit) exists; abort=1 in any non-IDLE state SHALL return to IDLE next cycle with busy=0, no done, no err, and total_cycles holding its partial value.
REQ-036 Without DATAFLOW_SCHED_ABORT_EN: port abort SHALL be absent, and a schedule SHALL end only via DONE or rst.

Verification
REQ-037 All tables =1, kernelsize=2, same=1, 1000/200, array_rdy=1 -> 5 round_valid pulses, df_sel=0, done, total_cycles=5.
REQ-038 Row 1: WSIS=3, others=5, same=0, 1001/200 -> 6 rounds, df_sel=2, total_cycles=18.
REQ-039 same=1, OSIS[1][0]=2 others 4; OSIS[1][1]=9, OSWS[1][1]=1; 2 rounds -> df_sel stays 0, total_cycles=11. Same stimulus with same=0 -> round-1 df_sel=1, total_cycles=3.
REQ-040 kernelsize=0, then kernelsize=17, then total_inputmapnum=0, each with start -> err pulse each, busy never rises.
REQ-041 array_rdy held low 20 cycles in WAIT -> no round_valid until it rises. Cost entry 0 -> round lasts 1 cycle.
REQ-042 rst asserted mid-RUN -> all outputs 0 at once, no done. With DATAFLOW_SCHED_ABORT_EN, abort mid-RUN -> IDLE next cycle.
